// File: rtl/rf_pkg.sv
// Shared widths, packed-port slicing helper and write-request type for the
// multiport register file and its scoreboard.
package rf_pkg;

    localparam int unsigned RF_DATA_W   = 16;
    localparam int unsigned RF_ADDR_W   = 3;
    localparam int unsigned RF_NUM_READ = 3;

    // Low bit of field idx inside a packed multi-port bus of width-bit fields
    function automatic int rf_slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    typedef struct packed {
        logic                 enable;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/multiport_register_file_if.sv
// Bus bundle of the multiport register file.
//   master : decode/writeback/operand-fetch side (drives writes, reserve, read addresses)
//   slave  : register file side (returns read data, pending flags, any_pending)
interface multiport_register_file_if
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_READ = RF_NUM_READ
) ();

    logic                         write_enable_0;
    logic [ADDR_W-1:0]            write_addr_0;
    logic [DATA_W-1:0]            write_data_0;
    logic                         write_enable_1;
    logic [ADDR_W-1:0]            write_addr_1;
    logic [DATA_W-1:0]            write_data_1;
    logic                         reserve_enable;
    logic [ADDR_W-1:0]            reserve_addr;
    logic [NUM_READ*ADDR_W-1:0]   read_addr;
    logic [NUM_READ*DATA_W-1:0]   read_data;
    logic [NUM_READ-1:0]          read_pending;
    logic                         any_pending;

    modport master (
        output write_enable_0, write_addr_0, write_data_0,
        output write_enable_1, write_addr_1, write_data_1,
        output reserve_enable, reserve_addr, read_addr,
        input  read_data, read_pending, any_pending
    );

    modport slave (
        input  write_enable_0, write_addr_0, write_data_0,
        input  write_enable_1, write_addr_1, write_data_1,
        input  reserve_enable, reserve_addr, read_addr,
        output read_data, read_pending, any_pending
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: reserve sets, write clears, reserve wins.
// Optional macro RF_BYPASS_EN: read-side pending shows the post-edge value.
// Ports: clk, RESET (sync, active-high), two write enables/addresses,
//        reserve enable/address, packed read addresses,
//        o_read_pending (per read port), o_any_pending (OR of all bits).
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_READ = RF_NUM_READ,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       RESET,
    input  logic                       i_we_0,
    input  logic [ADDR_W-1:0]          i_wa_0,
    input  logic                       i_we_1,
    input  logic [ADDR_W-1:0]          i_wa_1,
    input  logic                       i_reserve_en,
    input  logic [ADDR_W-1:0]          i_reserve_addr,
    input  logic [NUM_READ*ADDR_W-1:0] i_read_addr,
    output logic [NUM_READ-1:0]        o_read_pending,
    output logic                       o_any_pending
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]  r_pending;
    logic [DEPTH-1:0]  w_pending_next;
    logic [DEPTH-1:0]  w_pend_view;
    logic [ADDR_W-1:0] w_raddr;

    // Next pending vector: reserve beats write-clear; register 0 may be hardwired
    always_comb begin
        w_pending_next = r_pending;
        for (int r = 0; r < int'(DEPTH); r++) begin
            if (ZERO_REG != 0 && r == 0) begin
                w_pending_next[r] = 1'b0;
            end else if (i_reserve_en && i_reserve_addr == ADDR_W'(r)) begin
                w_pending_next[r] = 1'b1;
            end else if ((i_we_0 && i_wa_0 == ADDR_W'(r)) ||
                         (i_we_1 && i_wa_1 == ADDR_W'(r))) begin
                w_pending_next[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

`ifdef RF_BYPASS_EN
    assign w_pend_view = w_pending_next;
`else
    assign w_pend_view = r_pending;
`endif

    // Per-port pending lookup
    always_comb begin
        o_read_pending = '0;
        w_raddr        = '0;
        for (int k = 0; k < int'(NUM_READ); k++) begin
            w_raddr           = i_read_addr[rf_slice_lo(k, int'(ADDR_W)) +: ADDR_W];
            o_read_pending[k] = w_pend_view[w_raddr];
            if (ZERO_REG != 0 && w_raddr == '0) begin
                o_read_pending[k] = 1'b0;
            end
        end
    end

    assign o_any_pending = |r_pending;

endmodule

// File: rtl/multiport_register_file.sv
// Multiport register file: NUM_READ combinational read ports, two synchronous
// write ports (port 1 wins on address collision), per-register pending bits.
// Optional macro RF_BYPASS_EN: same-cycle write-to-read data/pending bypass.
// Ports: clk, RESET (sync, active-high), bus (multiport_register_file_if.slave).
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_READ = RF_NUM_READ,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       RESET,
    multiport_register_file_if.slave   bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_keep_0;
    logic              w_keep_1;
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rdata;

    // Writes to a hardwired register 0 are dropped
    assign w_keep_0 = bus.write_enable_0 && !(ZERO_REG != 0 && bus.write_addr_0 == '0);
    assign w_keep_1 = bus.write_enable_1 && !(ZERO_REG != 0 && bus.write_addr_1 == '0);

    // Storage; port 1 is written last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            if (w_keep_0) begin
                r_mem[bus.write_addr_0] <= bus.write_data_0;
            end
            if (w_keep_1) begin
                r_mem[bus.write_addr_1] <= bus.write_data_1;
            end
        end
    end

    // Combinational read ports
    always_comb begin
        bus.read_data = '0;
        w_raddr       = '0;
        w_rdata       = '0;
        for (int k = 0; k < int'(NUM_READ); k++) begin
            w_raddr = bus.read_addr[rf_slice_lo(k, int'(ADDR_W)) +: ADDR_W];
            w_rdata = r_mem[w_raddr];
`ifdef RF_BYPASS_EN
            if (bus.write_enable_1 && bus.write_addr_1 == w_raddr) begin
                w_rdata = bus.write_data_1;
            end else if (bus.write_enable_0 && bus.write_addr_0 == w_raddr) begin
                w_rdata = bus.write_data_0;
            end
`endif
            if (ZERO_REG != 0 && w_raddr == '0) begin
                w_rdata = '0;
            end
            bus.read_data[rf_slice_lo(k, int'(DATA_W)) +: DATA_W] = w_rdata;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_READ (NUM_READ),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk            (clk),
        .RESET          (RESET),
        .i_we_0         (bus.write_enable_0),
        .i_wa_0         (bus.write_addr_0),
        .i_we_1         (bus.write_enable_1),
        .i_wa_1         (bus.write_addr_1),
        .i_reserve_en   (bus.reserve_enable),
        .i_reserve_addr (bus.reserve_addr),
        .i_read_addr    (bus.read_addr),
        .o_read_pending (bus.read_pending),
        .o_any_pending  (bus.any_pending)
    );

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench: stimulus pushes expected values, a negedge monitor pops
// and compares. Two instances: ZERO_REG=0 (dut) and ZERO_REG=1 (dut_z),
// sharing identical inputs.
module tb_multiport_register_file;
    import rf_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned NR = 3;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiport_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) b ();
    multiport_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) bz ();

    assign bz.write_enable_0 = b.write_enable_0;
    assign bz.write_addr_0   = b.write_addr_0;
    assign bz.write_data_0   = b.write_data_0;
    assign bz.write_enable_1 = b.write_enable_1;
    assign bz.write_addr_1   = b.write_addr_1;
    assign bz.write_data_1   = b.write_data_1;
    assign bz.reserve_enable = b.reserve_enable;
    assign bz.reserve_addr   = b.reserve_addr;
    assign bz.read_addr      = b.read_addr;

    multiport_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(0)) dut (
        .clk(clk), .RESET(rst), .bus(b)
    );
    multiport_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1)) dut_z (
        .clk(clk), .RESET(rst), .bus(bz)
    );

    // sel: 0 data, 1 pending, 2 any (dut); 3 data, 4 pending, 5 any (dut_z)
    typedef struct {
        int          sel;
        int          port;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic expect_chk(input int sel, input int port, input logic [15:0] exp, input string name);
        chk_t c;
        c.sel = sel; c.port = port; c.exp = exp; c.name = name;
        q.push_back(c);
    endtask

    // Watchdog: a hung run is a failure
    initial begin
        #100000;
        $display("FAIL timeout: wait expired at %0t", $time);
        miscompares++;
        $finish;
    end

    // Monitor: outputs are combinational, so every queued entry is checked mid-cycle
    initial begin
        chk_t        c;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            while (q.size() != 0) begin
                c = q.pop_front();
                case (c.sel)
                    0:       act = b.read_data[c.port*16 +: 16];
                    1:       act = {15'b0, b.read_pending[c.port]};
                    2:       act = {15'b0, b.any_pending};
                    3:       act = bz.read_data[c.port*16 +: 16];
                    4:       act = {15'b0, bz.read_pending[c.port]};
                    default: act = {15'b0, bz.any_pending};
                endcase
                vectors++;
                if (act !== c.exp) begin
                    miscompares++;
                    $display("FAIL %s port%0d: got %h expected %h at %0t", c.name, c.port, act, c.exp, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        b.write_enable_0 = 1'b0;
        b.write_enable_1 = 1'b0;
        b.reserve_enable = 1'b0;
    endtask

    task automatic rd(input int a0, input int a1, input int a2);
        b.read_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic wr0(input rf_wr_req_t w);
        b.write_enable_0 = w.enable;
        b.write_addr_0   = w.addr;
        b.write_data_0   = w.data;
    endtask

    task automatic wr1(input rf_wr_req_t w);
        b.write_enable_1 = w.enable;
        b.write_addr_1   = w.addr;
        b.write_data_1   = w.data;
    endtask

    task automatic rsv(input int a);
        b.reserve_enable = 1'b1;
        b.reserve_addr   = AW'(a);
    endtask

    initial begin
        b.write_enable_0 = 1'b0; b.write_addr_0 = '0; b.write_data_0 = '0;
        b.write_enable_1 = 1'b0; b.write_addr_1 = '0; b.write_data_1 = '0;
        b.reserve_enable = 1'b0; b.reserve_addr = '0; b.read_addr = '0;

        // 1. reset for two edges, then everything reads zero
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        vectors++;
        if (b.read_data !== '0 || b.read_pending !== '0 || b.any_pending !== 1'b0 ||
            bz.read_data !== '0 || bz.read_pending !== '0 || bz.any_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: data %h pend %b any %b at %0t",
                     b.read_data, b.read_pending, b.any_pending, $time);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            rd(i, (i + 1) % 8, (i + 2) % 8);
            for (int k = 0; k < 3; k++) begin
                expect_chk(0, k, 16'h0000, "reset_data");
                expect_chk(1, k, 16'h0000, "reset_pend");
            end
            expect_chk(2, 0, 16'h0000, "reset_any");
        end

        // 2. fill addr i with 1<<(2i) through port 0, read back rotated
        for (int i = 0; i < 8; i++) begin
            step();
            wr0('{enable: 1'b1, addr: AW'(i), data: 16'(1) << (2 * i)});
        end
        for (int i = 0; i < 8; i++) begin
            step();
            rd(i, (i + 1) % 8, (i + 2) % 8);
            for (int k = 0; k < 3; k++)
                expect_chk(0, k, 16'(1) << (2 * ((i + k) % 8)), "fill_rd");
        end
        step();
        rd(3, 3, 3);
        for (int k = 0; k < 3; k++) expect_chk(0, k, 16'h0040, "shared_addr");

        // 3. collision then parallel dual write
        step();
        wr0('{enable: 1'b1, addr: 3'd5, data: 16'h1111});
        wr1('{enable: 1'b1, addr: 3'd5, data: 16'h2222});
        step();
        wr0('{enable: 1'b1, addr: 3'd2, data: 16'hAAAA});
        wr1('{enable: 1'b1, addr: 3'd3, data: 16'hBBBB});
        rd(5, 0, 7);
        expect_chk(0, 0, 16'h2222, "collision");
        step();
        rd(2, 3, 5);
        expect_chk(0, 0, 16'hAAAA, "dual_wr_a");
        expect_chk(0, 1, 16'hBBBB, "dual_wr_b");
        expect_chk(0, 2, 16'h2222, "dual_wr_keep");

        // 4. scoreboard
        step();
        rsv(4);
        step();
        rd(4, 1, 2);
        expect_chk(1, 0, 16'h0001, "rsv_pend");
        expect_chk(1, 1, 16'h0000, "rsv_other");
        expect_chk(2, 0, 16'h0001, "rsv_any");
        step();
        wr0('{enable: 1'b1, addr: 3'd4, data: 16'h4444});
        rd(1, 2, 0);
        step();
        rd(4, 4, 0);
        expect_chk(1, 0, 16'h0000, "clr_pend");
        expect_chk(2, 0, 16'h0000, "clr_any");
        expect_chk(0, 1, 16'h4444, "clr_data");
        step();
        rsv(6);
        wr1('{enable: 1'b1, addr: 3'd6, data: 16'h6666});
        rd(1, 2, 0);
        step();
        rd(6, 6, 0);
        expect_chk(1, 0, 16'h0001, "rsv_wr_pend");
        expect_chk(1, 1, 16'h0001, "rsv_wr_pend");
        expect_chk(1, 2, 16'h0000, "rsv_wr_other");
        expect_chk(2, 0, 16'h0001, "rsv_wr_any");
        expect_chk(0, 0, 16'h6666, "rsv_wr_data");
        step();
        wr0('{enable: 1'b1, addr: 3'd6, data: 16'h6666});
        rd(1, 2, 0);
        step();
        rd(6, 0, 0);
        expect_chk(2, 0, 16'h0000, "retire_any");
        expect_chk(1, 0, 16'h0000, "retire_pend");

        // 5. same-cycle write/read of addr 7; reserve addr 1 in the same cycle
        step();
        wr0('{enable: 1'b1, addr: 3'd7, data: 16'h1234});
        rsv(1);
        rd(7, 7, 1);
        expect_chk(0, 0, BYP ? 16'h1234 : 16'h4000, "bypass_data");
        expect_chk(0, 1, BYP ? 16'h1234 : 16'h4000, "bypass_data");
        expect_chk(1, 2, BYP ? 16'h0001 : 16'h0000, "bypass_pend");
        expect_chk(0, 2, 16'h0004, "bypass_other");
        step();
        rd(7, 1, 1);
        expect_chk(0, 0, 16'h1234, "post_wr_data");
        expect_chk(1, 1, 16'h0001, "post_rsv_pend");
        expect_chk(2, 0, 16'h0001, "post_rsv_any");
        step();
        wr0('{enable: 1'b1, addr: 3'd1, data: 16'h0004});
        rd(0, 2, 3);
        step();
        expect_chk(2, 0, 16'h0000, "idle_any");

        // 6a. write + reserve colliding with RESET
        step();
        rst = 1'b1;
        wr0('{enable: 1'b1, addr: 3'd2, data: 16'hDEAD});
        wr1('{enable: 1'b1, addr: 3'd3, data: 16'hBEEF});
        rsv(5);
        step();
        rst = 1'b0;
        rd(2, 3, 5);
        for (int k = 0; k < 3; k++) begin
            expect_chk(0, k, 16'h0000, "rst_mid_data");
            expect_chk(1, k, 16'h0000, "rst_mid_pend");
        end
        expect_chk(2, 0, 16'h0000, "rst_mid_any");
        expect_chk(5, 0, 16'h0000, "rst_mid_any_z");
        step();
        rd(7, 6, 4);
        expect_chk(0, 0, 16'h0000, "rst_mid_data");
        expect_chk(0, 1, 16'h0000, "rst_mid_data");

        // 6b. register 0 write + reserve: hardwired on dut_z, normal on dut
        step();
        wr0('{enable: 1'b1, addr: 3'd0, data: 16'hFFFF});
        rsv(0);
        rd(0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            expect_chk(3, k, 16'h0000, "zero_data_now");
            expect_chk(4, k, 16'h0000, "zero_pend_now");
        end
        expect_chk(0, 0, BYP ? 16'hFFFF : 16'h0000, "r0_data_now");
        expect_chk(1, 0, BYP ? 16'h0001 : 16'h0000, "r0_pend_now");
        step();
        rd(0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            expect_chk(3, k, 16'h0000, "zero_data");
            expect_chk(4, k, 16'h0000, "zero_pend");
        end
        expect_chk(5, 0, 16'h0000, "zero_any");
        expect_chk(0, 0, 16'hFFFF, "r0_data");
        expect_chk(1, 0, 16'h0001, "r0_pend");
        expect_chk(2, 0, 16'h0001, "r0_any");

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares != 0) begin
            $display("FAIL: %0d miscompares", miscompares);
        end else begin
            $display("PASS");
        end
        $finish;
    end

endmodule
